// File: rtl/apb_master_pkg.sv
// Shared command opcodes and FSM state encoding for the APB read/write/RMW master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_RMW_ADD = 2'b10,
    OP_WRITE   = 2'b11
  } apb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } apb_mst_state_t;

endpackage

// File: rtl/apb_access_wdog.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags the cycle on which
// the TIMEOUT_CYCLES-th consecutive wait state would complete.
module apb_access_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic enable,
  input  logic clear,
  input  logic pready,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !pready && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag on the cycle whose end completes the last allowed wait state.
  assign expired = enable && !pready && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_rmw_master.sv
// APB master executing READ, WRITE and atomic RMW_ADD commands with a one-cycle
// response pulse. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
//
// state     | meaning
// ST_IDLE   | ready for a command
// ST_SETUP  | APB setup phase (psel=1, penable=0)
// ST_ACCESS | APB access phase, waiting for pready
// ST_RESP   | one-cycle response pulse
module apb_rmw_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_rmw_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_mst_state_t    state_q, state_d;
  apb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              wr_phase_q, wr_phase_d;

  logic              accept;
  logic              to_expired;
  logic [DATA_W-1:0] sum;

`ifdef APB_TIMEOUT_EN
  apb_access_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .pclk    (pclk),
    .preset_n(preset_n),
    .enable  (state_q == ST_ACCESS),
    .clear   (state_q == ST_SETUP),
    .pready  (pready_i),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  assign accept = cmd_valid_i && cmd_ready_o;
  // Carry out of the top bit is discarded: the sum wraps modulo 2^DATA_W.
  assign sum    = rdata_q + data_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wr_phase_d = wr_phase_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = apb_op_t'(cmd_op_i);
          addr_d     = cmd_addr_i;
          data_d     = cmd_data_i;
          rdata_d    = '0;
          err_d      = 1'b0;
          wr_phase_d = 1'b0;
          if (apb_op_t'(cmd_op_i) != OP_NOP) begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          err_d = pslverr_i;
          if (!wr_phase_q && (op_q != OP_WRITE)) begin
            rdata_d = prdata_i;
          end
          if ((op_q == OP_RMW_ADD) && !wr_phase_q && !pslverr_i) begin
            state_d    = ST_SETUP;
            wr_phase_d = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end else if (to_expired) begin
          // Timeout reports an error with no data and drops any pending write.
          state_d    = ST_RESP;
          err_d      = 1'b1;
          rdata_d    = '0;
          wr_phase_d = 1'b0;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        wr_phase_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wr_phase_q <= wr_phase_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = psel_o ? addr_q : '0;
  assign pwrite_o    = psel_o && ((op_q == OP_WRITE) || wr_phase_q);
  assign pwdata_o    = pwrite_o ? (wr_phase_q ? sum : data_q) : '0;

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule
